// File: rtl/map_reveal_pkg.sv
// ============================================================================
// map_reveal_pkg : shared map geometry and cell encoding        rev 1.0
// ============================================================================
`default_nettype none

package map_reveal_pkg;

    localparam int MAP_WIDTH       = 8;
    localparam int MAP_HEIGHT      = 8;
    localparam int MAP_CELL_LENGTH = 4;
    localparam int IS_MINE         = 15;

    typedef logic [2:0] coord_t;

    function automatic int idx_of(input int x, input int y, input int width);
        return x + y * width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/map_reveal_index_stack.sv
// ============================================================================
// index_stack : DEPTH-deep LIFO of cell indices with synchronous clear  rev 1.0
// ============================================================================
`default_nettype none

module index_stack #(
    parameter int DEPTH = 64,
    parameter int IW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [IW-1:0] push_data,
    output logic [IW-1:0] top,
    output logic          empty
);

    logic [IW-1:0] mem [DEPTH];
    logic [IW:0]   sp;
    logic [IW:0]   sp_dec;

    assign sp_dec = sp - (IW+1)'(1);
    assign empty  = (sp == '0);
    assign top    = empty ? '0 : mem[sp_dec[IW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (clear) begin
            sp <= '0;
        end else if (push) begin
            sp <= sp + (IW+1)'(1);
        end else if (pop) begin
            sp <= sp_dec;
        end
    end

    // Storage needs no reset: entries above sp are never read.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[sp[IW-1:0]] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/map_reveal.sv
// ============================================================================
// map_reveal : click handling, flood-fill reveal mask, lose/win flags  rev 1.0
// ============================================================================
`default_nettype none

module map_reveal
    import map_reveal_pkg::*;
#(
    parameter int MAP_WIDTH  = map_reveal_pkg::MAP_WIDTH,
    parameter int MAP_HEIGHT = map_reveal_pkg::MAP_HEIGHT,
    parameter int CELL_LEN   = map_reveal_pkg::MAP_CELL_LENGTH,
    parameter int IS_MINE    = map_reveal_pkg::IS_MINE
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   clear_i,
    input  logic [CELL_LEN*MAP_WIDTH*MAP_HEIGHT-1:0] map_i,
    input  logic                                   click_valid_i,
    input  logic [2:0]                             click_x_i,
    input  logic [2:0]                             click_y_i,
    output logic                                   click_ready_o,
    output logic [MAP_WIDTH*MAP_HEIGHT-1:0]        revealed_o,
    output logic                                   busy_o,
    output logic                                   hit_mine_o,
    output logic                                   win_o
);

    localparam int N  = MAP_WIDTH * MAP_HEIGHT;
    localparam int IW = $clog2(N);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_POP   = 2'd2;
    localparam logic [1:0] S_SCAN  = 2'd3;

    logic [1:0]    state;
    coord_t        click_x;
    coord_t        click_y;
    logic [IW-1:0] cur;
    logic [2:0]    k;
    logic [N-1:0]  revealed;
    logic [N-1:0]  mine_mask;
    logic          hit_mine;
    logic          win;

    logic [CELL_LEN-1:0] cur_cell;
    logic [CELL_LEN-1:0] nb_cell;
    logic                click_oob;
    logic                cur_fresh;
    logic                nb_in_bounds;
    logic                nb_ok;
    logic [IW-1:0]       nb_idx;
    logic                push;
    logic                pop;
    logic [IW-1:0]       push_data;
    logic [IW-1:0]       stack_top;
    logic                stack_empty;
    int                  cx, cy, dx, dy, nx, ny;

    for (genvar i = 0; i < N; i++) begin : g_mine
        assign mine_mask[i] = (map_i[CELL_LEN*i +: CELL_LEN] == CELL_LEN'(IS_MINE));
    end

    // Neighbour order NW, N, NE, W, E, SW, S, SE; bounds are checked on
    // (x, y) so a step off column MAP_WIDTH-1 never wraps to the next row.
    always_comb begin
        cur_cell  = map_i[CELL_LEN*int'(cur) +: CELL_LEN];
        click_oob = (int'(click_x) >= MAP_WIDTH) || (int'(click_y) >= MAP_HEIGHT);
        cur_fresh = !click_oob && !revealed[cur];
        cx = int'(cur) % MAP_WIDTH;
        cy = int'(cur) / MAP_WIDTH;
        case (k)
            3'd0:    begin dx = -1; dy = -1; end
            3'd1:    begin dx =  0; dy = -1; end
            3'd2:    begin dx =  1; dy = -1; end
            3'd3:    begin dx = -1; dy =  0; end
            3'd4:    begin dx =  1; dy =  0; end
            3'd5:    begin dx = -1; dy =  1; end
            3'd6:    begin dx =  0; dy =  1; end
            default: begin dx =  1; dy =  1; end
        endcase
        nx = cx + dx;
        ny = cy + dy;
        nb_in_bounds = (nx >= 0) && (nx < MAP_WIDTH) && (ny >= 0) && (ny < MAP_HEIGHT);
        nb_idx  = nb_in_bounds ? IW'(idx_of(nx, ny, MAP_WIDTH)) : '0;
        nb_cell = map_i[CELL_LEN*int'(nb_idx) +: CELL_LEN];
        nb_ok   = nb_in_bounds && !revealed[nb_idx] && !mine_mask[nb_idx];

        push = ((state == S_CHECK) && cur_fresh && !mine_mask[cur] && (cur_cell == '0)) ||
               ((state == S_SCAN)  && nb_ok && (nb_cell == '0));
        pop       = (state == S_POP) && !stack_empty;
        push_data = (state == S_CHECK) ? cur : nb_idx;
    end

    index_stack #(
        .DEPTH (N),
        .IW    (IW)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear_i),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .top       (stack_top),
        .empty     (stack_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            click_x  <= '0;
            click_y  <= '0;
            cur      <= '0;
            k        <= '0;
            revealed <= '0;
            hit_mine <= 1'b0;
            win      <= 1'b0;
        end else if (clear_i) begin
            state    <= S_IDLE;
            click_x  <= '0;
            click_y  <= '0;
            cur      <= '0;
            k        <= '0;
            revealed <= '0;
            hit_mine <= 1'b0;
            win      <= 1'b0;
        end else begin
            win <= win | (&(revealed | mine_mask));
            case (state)
                S_IDLE: begin
                    if (click_valid_i && click_ready_o) begin
                        click_x <= click_x_i;
                        click_y <= click_y_i;
                        cur     <= IW'(idx_of(int'(click_x_i), int'(click_y_i), MAP_WIDTH));
                        state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    state <= S_IDLE;
                    if (cur_fresh) begin
                        revealed[cur] <= 1'b1;
                        if (mine_mask[cur]) begin
                            hit_mine <= 1'b1;
                        end else if (cur_cell == '0) begin
                            state <= S_POP;
                        end
                    end
                end
                S_POP: begin
                    if (stack_empty) begin
                        state <= S_IDLE;
                    end else begin
                        cur   <= stack_top;
                        k     <= '0;
                        state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (nb_ok) begin
                        revealed[nb_idx] <= 1'b1;
                    end
                    k <= k + 3'd1;
                    if (k == 3'd7) begin
                        state <= S_POP;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign click_ready_o = (state == S_IDLE) && !hit_mine && !win;
    assign busy_o        = (state != S_IDLE);
    assign revealed_o    = revealed;
    assign hit_mine_o    = hit_mine;
    assign win_o         = win;

endmodule

`default_nettype wire

// File: doc/map_reveal.md
# map_reveal

Consumer of the generated minesweeper map: accepts player clicks as (x, y) cell coordinates, reads the flattened map word, and maintains the per-cell "revealed" mask used by the display path. A click on a zero-count cell triggers a stack-based flood fill that reveals the connected zero region and its numbered border. The block also raises sticky lose and win flags. It sits between the map generator and the screen/state controller.

## Interface
- MAP_WIDTH, default `MAP_WIDTH (8): columns; x index range 0..MAP_WIDTH-1.
- MAP_HEIGHT, default `MAP_HEIGHT (8): rows; y index range 0..MAP_HEIGHT-1.
- CELL_LEN, default `MAP_CELL_LENGTH (4): bits per map cell.
- IS_MINE, default `IS_MINE: cell code for a mine; other codes are neighbour counts 0..8.
- N = MAP_WIDTH*MAP_HEIGHT (localparam); IW = $clog2(N) (localparam).
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous new-game clear, one cycle.
- map_i  in  CELL_LEN*N  map; cell i occupies bits [CELL_LEN*(i+1)-1 : CELL_LEN*i], i = x + y*MAP_WIDTH. Held stable while the game is in play.
- click_valid_i  in  1  click request.
- click_x_i  in  3  click column.
- click_y_i  in  3  click row.
- click_ready_o  out  1  click accepted when click_valid_i && click_ready_o at a rising edge.
- revealed_o  out  N  bit i = cell i revealed.
- busy_o  out  1  request or fill in progress.
- hit_mine_o  out  1  sticky: a mine was clicked.
- win_o  out  1  sticky: all non-mine cells revealed.

## Operation
- Reset (async) and clear_i (sync, highest priority) are equivalent: revealed_o=0, stack empty, hit_mine_o=0, win_o=0, state IDLE, click_ready_o=1, busy_o=0.
- click_ready_o = (state==IDLE) && !hit_mine_o && !win_o. busy_o = (state!=IDLE).
- States: IDLE, CHECK, POP, SCAN.
- IDLE: on handshake, latch x, y and cur = x + y*MAP_WIDTH; go to CHECK.
- CHECK: x>=MAP_WIDTH or y>=MAP_HEIGHT, or cell already revealed -> no change, go to IDLE. Mine -> set revealed[cur] and hit_mine_o, go to IDLE. Count>0 -> set revealed[cur], go to IDLE. Count==0 -> set revealed[cur], push cur, go to POP.
- POP: if stack is empty, go to IDLE. Otherwise pop into cur, set k=0, go to SCAN.
- SCAN: one neighbour per cycle, k=0..7 in the order NW, N, NE, W, E, SW, S, SE. A neighbour is skipped if it is out of bounds (column wrap across MAP_WIDTH is prohibited), already revealed, or a mine. Otherwise set its revealed bit and, if its count is 0, push its index. After k=7, go to POP.
- A cell's revealed bit is set in the same cycle it is pushed. Each cell is therefore pushed at most once, and a stack of depth N never overflows. Push and pop never occur in the same cycle.
- win_o is registered: it sets on the cycle after (revealed_o | mine_mask) becomes all-ones. hit_mine_o and win_o remain set until clear_i or reset.

## Timing
- Handshake at edge T; CHECK result (revealed bit, hit_mine_o) is visible after edge T+1.
- Count>0 click: click_ready_o is high again after edge T+1.
- Zero-cell fill: 1 POP cycle plus 8 SCAN cycles per pushed cell, plus 1 final POP. Worst case 9*N+2 cycles.
- clear_i mid-fill aborts immediately: next cycle is IDLE with all outputs at their reset values.
- click_valid_i while not ready is ignored; there is no queueing.

## Structure
- Shared header: MAP_WIDTH, MAP_HEIGHT, MAP_CELL_LENGTH, IS_MINE. Neighbour-order encoding is local.
- Sub-module: index_stack, an N-deep LIFO of IW-bit entries with push/pop/empty and a synchronous clear.
- Neighbour address and bounds logic is combinational from cur and k, inside map_reveal.

## Test plan
- Reset then click (3,3) on a count-2 cell -> revealed_o has only bit 27 set, after 2 edges; busy_o high for 1 cycle.
- Click a mine at (0,0) -> revealed_o[0]=1, hit_mine_o=1. A further click on (5,5) is never accepted (click_ready_o=0).
- Map with a single mine at (7,7), click (0,0) -> fill reveals all 63 non-mine cells; win_o=1 and the mine bit stays 0; completes within 9*64+2 cycles.
- Zero region bounded at column 7, row 0 -> no revealed bits appear in column 0 of the next row (no wrap).
- Assert clear_i mid-fill -> revealed_o=0, busy_o=0, click_ready_o=1 on the next cycle. A fresh click then behaves normally.
- Click an already revealed cell, and a click with x=7, y=7 on a smaller-parameter map (6x6) -> no state change, ready again after 2 edges.
